race_motion_scheduler: RTL and testbench

Per-frame motion sequencer for the race game. It sits between the keyboard decoder, VGA sync and game-state controller, and the graphics block. Once per video frame, during vertical blank, it turns keyboard direction requests into car position updates, advances the road scroll offset, and ramps scroll speed. Graphics reads its registered outputs, so all object motion changes only outside the active display region.

---
 rtl/race_motion_scheduler.sv | 172 +++++++++++++++++
 tb/tb_race_motion_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/race_motion_scheduler.sv
// Per-frame motion sequencer: detects the vertical-blank frame boundary and then steps car_x, scroll_y and speed.
// Optional speed ramp is enabled by defining RACE_SPEED_RAMP_EN.
module race_motion_scheduler #(
    parameter int CAR_X_INIT  = 300,
    parameter int CAR_X_MIN   = 160,
    parameter int CAR_X_MAX   = 460,
    parameter int STEP        = 4,
    parameter int V_ACTIVE    = 480,
    parameter int SPEED_INIT  = 1,
    parameter int SPEED_MAX   = 7,
    parameter int RAMP_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       run_en,
    input  logic       hold,
    input  logic       left_key,
    input  logic       right_key,
    input  logic       key_release,
    output logic       frame_tick,
    output logic [9:0] car_x,
    output logic [9:0] scroll_y,
    output logic [2:0] speed,
    output logic       busy
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MOVE, S_SCROLL, S_RAMP} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [9:0]  X_INIT  = 10'(CAR_X_INIT);
    localparam logic [9:0]  X_MIN   = 10'(CAR_X_MIN);
    localparam logic [9:0]  X_MAX   = 10'(CAR_X_MAX);
    localparam logic [9:0]  X_STEP  = 10'(STEP);
    localparam logic [10:0] X_MIN_W = 11'(CAR_X_MIN);
    localparam logic [10:0] X_MAX_W = 11'(CAR_X_MAX);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [9:0]  V_LINE  = 10'(V_ACTIVE);
    localparam logic [10:0] V_MOD   = 11'(V_ACTIVE);
    localparam logic [2:0]  SPD_INIT = 3'(SPEED_INIT);

`ifdef RACE_SPEED_RAMP_EN
    localparam int              CNT_W    = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_FRAMES - 1);
    localparam logic [2:0]       SPD_MAX  = 3'(SPEED_MAX);
    logic [CNT_W-1:0] frame_cnt, frame_cnt_next;
`endif

    state_t      state, state_next;
    dir_t        dir;
    logic        cond, cond_d;
    logic [9:0]  car_x_next, scroll_next;
    logic [2:0]  speed_next;
    logic [10:0] car_sum, scroll_sum;

    // The pixel counters hold each value for several clocks, so only the rising edge of cond is a frame boundary.
    assign cond = (pixel_y == V_LINE) && (pixel_x == 10'd0);

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            cond_d     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            cond_d     <= cond;
            frame_tick <= cond & ~cond_d;
        end
    end

    // Simultaneous left/right cancels; a key strobe wins over a release in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset)                    dir <= DIR_NONE;
        else if (left_key && right_key) dir <= DIR_NONE;
        else if (left_key)             dir <= DIR_LEFT;
        else if (right_key)            dir <= DIR_RIGHT;
        else if (key_release)          dir <= DIR_NONE;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        state_next  = state;
        car_x_next  = car_x;
        scroll_next = scroll_y;
        speed_next  = speed;
`ifdef RACE_SPEED_RAMP_EN
        frame_cnt_next = frame_cnt;
`endif
        car_sum    = {1'b0, car_x} + STEP_W;
        scroll_sum = {1'b0, scroll_y} + {8'd0, speed};

        case (state)
            S_IDLE: begin
                car_x_next  = X_INIT;
                scroll_next = 10'd0;
                speed_next  = 3'd0;
`ifdef RACE_SPEED_RAMP_EN
                frame_cnt_next = '0;
`endif
                if (run_en) begin
                    speed_next = SPD_INIT;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (frame_tick && !hold) state_next = S_MOVE;
            end
            S_MOVE: begin
                // Left is checked before subtracting so the clamp never sees an underflowed value.
                if (dir == DIR_LEFT) begin
                    if ({1'b0, car_x} < X_MIN_W + STEP_W) car_x_next = X_MIN;
                    else                                 car_x_next = car_x - X_STEP;
                end else if (dir == DIR_RIGHT) begin
                    if (car_sum > X_MAX_W) car_x_next = X_MAX;
                    else                   car_x_next = car_sum[9:0];
                end
                state_next = S_SCROLL;
            end
            S_SCROLL: begin
                if (scroll_sum >= V_MOD) scroll_next = 10'(scroll_sum - V_MOD);
                else                     scroll_next = scroll_sum[9:0];
                state_next = S_RAMP;
            end
            S_RAMP: begin
`ifdef RACE_SPEED_RAMP_EN
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt_next = '0;
                    if (speed < SPD_MAX) speed_next = speed + 3'd1;
                end else begin
                    frame_cnt_next = frame_cnt + CNT_W'(1);
                end
`endif
                state_next = S_WAIT;
            end
            default: state_next = S_IDLE;
        endcase

        // Dropping run_en abandons any update and loads the idle values on the same edge.
        if (!run_en) begin
            state_next  = S_IDLE;
            car_x_next  = X_INIT;
            scroll_next = 10'd0;
            speed_next  = 3'd0;
`ifdef RACE_SPEED_RAMP_EN
            frame_cnt_next = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            car_x    <= X_INIT;
            scroll_y <= 10'd0;
            speed    <= 3'd0;
            busy     <= 1'b0;
`ifdef RACE_SPEED_RAMP_EN
            frame_cnt <= '0;
`endif
        end else begin
            state    <= state_next;
            car_x    <= car_x_next;
            scroll_y <= scroll_next;
            speed    <= speed_next;
            busy     <= (state_next == S_MOVE) || (state_next == S_SCROLL) || (state_next == S_RAMP);
`ifdef RACE_SPEED_RAMP_EN
            frame_cnt <= frame_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_race_motion_scheduler.sv
// Directed self-checking bench for race_motion_scheduler; a behavioural frame model supplies expected values.
// Ramp checks follow RACE_SPEED_RAMP_EN, with RAMP_FRAMES=2 on the instance.
module tb_race_motion_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] pixel_x = 10'd5;
    logic [9:0] pixel_y = 10'd0;
    logic       run_en = 1'b0, hold = 1'b0;
    logic       left_key = 1'b0, right_key = 1'b0, key_release = 1'b0;
    logic       frame_tick, busy;
    logic [9:0] car_x, scroll_y;
    logic [2:0] speed;

    int errors = 0;
    int checks = 0;

    int exp_x, exp_scroll, exp_spd, exp_cnt, exp_dir;  // exp_dir: 0 none, 1 left, 2 right
    bit wrap_seen = 1'b0;

    int   tick_total = 0, wide_total = 0, busy_total = 0;
    logic ft_prev = 1'b0;

    race_motion_scheduler #(.RAMP_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .run_en(run_en), .hold(hold), .left_key(left_key), .right_key(right_key),
        .key_release(key_release), .frame_tick(frame_tick), .car_x(car_x),
        .scroll_y(scroll_y), .speed(speed), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_tick) tick_total <= tick_total + 1;
        if (frame_tick && ft_prev) wide_total <= wide_total + 1;
        if (busy) busy_total <= busy_total + 1;
        ft_prev <= frame_tick;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame boundary: cond held 4 clocks, then the counters move on.
    task automatic do_frame();
        pixel_y = 10'd480; pixel_x = 10'd0; repeat (4) tick();
        pixel_x = 10'd1; repeat (4) tick();
        pixel_y = 10'd0; pixel_x = 10'd5; repeat (4) tick();
    endtask

    task automatic model_frame();
        if (exp_dir == 1)      exp_x = (exp_x < 164) ? 160 : exp_x - 4;
        else if (exp_dir == 2) exp_x = (exp_x + 4 > 460) ? 460 : exp_x + 4;
        exp_scroll = exp_scroll + exp_spd;
        if (exp_scroll >= 480) begin
            exp_scroll = exp_scroll - 480;
            wrap_seen = 1'b1;
        end
`ifdef RACE_SPEED_RAMP_EN
        if (exp_cnt == 1) begin
            exp_cnt = 0;
            if (exp_spd < 7) exp_spd = exp_spd + 1;
        end else exp_cnt = exp_cnt + 1;
`endif
    endtask

    task automatic strobe(input bit l, input bit r, input bit rel);
        left_key = l; right_key = r; key_release = rel;
        tick();
        left_key = 1'b0; right_key = 1'b0; key_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; run_en = 1'b0;
        repeat (3) tick();
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", frame_tick); end
        checks++; if (car_x !== 10'd300) begin errors++; $display("FAIL reset_car_x: got %0d expected 300", car_x); end
        checks++; if (scroll_y !== 10'd0) begin errors++; $display("FAIL reset_scroll: got %0d expected 0", scroll_y); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_run();
        int t0, w0, old_x, old_s, old_spd;
        run_en = 1'b1;
        tick();
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL start_speed: got %0d expected 1", speed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_busy: got %0b expected 0", busy); end
        exp_x = 300; exp_scroll = 0; exp_spd = 1; exp_cnt = 0; exp_dir = 0;
        t0 = tick_total; w0 = wide_total;
        repeat (2) begin do_frame(); model_frame(); end
        // Third frame walked cycle by cycle against the documented latency.
        old_x = exp_x; old_s = exp_scroll; old_spd = exp_spd;
        model_frame();
        pixel_y = 10'd480; pixel_x = 10'd0;
        tick();
        checks++; if (frame_tick !== 1'b1) begin errors++; $display("FAIL n1_tick: got %0b expected 1", frame_tick); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n1_busy: got %0b expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL n2_busy: got %0b expected 1", busy); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL n2_tick: got %0b expected 0", frame_tick); end
        checks++; if (car_x !== 10'(old_x)) begin errors++; $display("FAIL n2_car_x: got %0d expected %0d", car_x, old_x); end
        tick();
        checks++; if (car_x !== 10'(exp_x)) begin errors++; $display("FAIL n3_car_x: got %0d expected %0d", car_x, exp_x); end
        checks++; if (scroll_y !== 10'(old_s)) begin errors++; $display("FAIL n3_scroll: got %0d expected %0d", scroll_y, old_s); end
        tick();
        checks++; if (scroll_y !== 10'(exp_scroll)) begin errors++; $display("FAIL n4_scroll: got %0d expected %0d", scroll_y, exp_scroll); end
        checks++; if (speed !== 3'(old_spd)) begin errors++; $display("FAIL n4_speed: got %0d expected %0d", speed, old_spd); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL n4_busy: got %0b expected 1", busy); end
        pixel_x = 10'd1;
        tick();
        checks++; if (speed !== 3'(exp_spd)) begin errors++; $display("FAIL n5_speed: got %0d expected %0d", speed, exp_spd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n5_busy: got %0b expected 0", busy); end
        repeat (3) tick();
        pixel_y = 10'd0; pixel_x = 10'd5; repeat (4) tick();
        checks++; if (car_x !== 10'd300) begin errors++; $display("FAIL run3_car_x: got %0d expected 300", car_x); end
`ifndef RACE_SPEED_RAMP_EN
        checks++; if (scroll_y !== 10'd3) begin errors++; $display("FAIL run3_scroll: got %0d expected 3", scroll_y); end
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL run3_speed: got %0d expected 1", speed); end
`endif
        checks++; if (tick_total - t0 !== 3) begin errors++; $display("FAIL tick_count: got %0d expected 3", tick_total - t0); end
        checks++; if (wide_total - w0 !== 0) begin errors++; $display("FAIL tick_width: got %0d wide pulses expected 0", wide_total - w0); end
    endtask

    task automatic test_left_saturate();
        strobe(1'b1, 1'b0, 1'b0); exp_dir = 1;
        for (int f = 0; f < 50; f++) begin
            do_frame(); model_frame();
            checks++; if (car_x !== 10'(exp_x) || car_x < 10'd160) begin errors++; $display("FAIL left_frame%0d: got %0d expected %0d", f, car_x, exp_x); end
        end
        strobe(1'b0, 1'b0, 1'b1); exp_dir = 0;
        repeat (3) begin do_frame(); model_frame(); end
        checks++; if (car_x !== 10'd160) begin errors++; $display("FAIL left_release: got %0d expected 160", car_x); end
    endtask

    task automatic test_both_keys();
        strobe(1'b1, 1'b1, 1'b0); exp_dir = 0;
        do_frame(); model_frame();
        checks++; if (car_x !== 10'd160) begin errors++; $display("FAIL both_keys: got %0d expected 160", car_x); end
        strobe(1'b0, 1'b1, 1'b0); exp_dir = 2;
        do_frame(); model_frame();
        checks++; if (car_x !== 10'd164) begin errors++; $display("FAIL right_first: got %0d expected 164", car_x); end
        for (int f = 0; f < 80; f++) begin
            do_frame(); model_frame();
            checks++; if (car_x !== 10'(exp_x) || car_x > 10'd460) begin errors++; $display("FAIL right_frame%0d: got %0d expected %0d", f, car_x, exp_x); end
        end
        checks++; if (car_x !== 10'd460) begin errors++; $display("FAIL right_sat: got %0d expected 460", car_x); end
        strobe(1'b1, 1'b0, 1'b1); exp_dir = 1;
        do_frame(); model_frame();
        checks++; if (car_x !== 10'd456) begin errors++; $display("FAIL key_over_release: got %0d expected 456", car_x); end
    endtask

    task automatic test_hold();
        int b0;
        logic [9:0] hx, hs;
        logic [2:0] hspd;
        hx = car_x; hs = scroll_y; hspd = speed;
        hold = 1'b1; b0 = busy_total;
        repeat (5) do_frame();
        checks++; if (car_x !== hx) begin errors++; $display("FAIL hold_car_x: got %0d expected %0d", car_x, hx); end
        checks++; if (scroll_y !== hs) begin errors++; $display("FAIL hold_scroll: got %0d expected %0d", scroll_y, hs); end
        checks++; if (speed !== hspd) begin errors++; $display("FAIL hold_speed: got %0d expected %0d", speed, hspd); end
        checks++; if (busy_total - b0 !== 0) begin errors++; $display("FAIL hold_busy: got %0d busy cycles expected 0", busy_total - b0); end
        hold = 1'b0;
        do_frame(); model_frame();
        checks++; if (car_x !== 10'd452) begin errors++; $display("FAIL resume_car_x: got %0d expected 452", car_x); end
        checks++; if (scroll_y !== 10'(exp_scroll)) begin errors++; $display("FAIL resume_scroll: got %0d expected %0d", scroll_y, exp_scroll); end
        checks++; if (speed !== 3'(exp_spd)) begin errors++; $display("FAIL resume_speed: got %0d expected %0d", speed, exp_spd); end
        // hold raised once the update has started must not cut it short
        pixel_y = 10'd480; pixel_x = 10'd0;
        tick(); tick();
        hold = 1'b1;
        repeat (2) tick();
        pixel_x = 10'd1; repeat (4) tick();
        pixel_y = 10'd0; pixel_x = 10'd5; repeat (4) tick();
        model_frame();
        hold = 1'b0;
        checks++; if (car_x !== 10'd448) begin errors++; $display("FAIL hold_midupdate_x: got %0d expected 448", car_x); end
        checks++; if (speed !== 3'(exp_spd)) begin errors++; $display("FAIL hold_midupdate_spd: got %0d expected %0d", speed, exp_spd); end
    endtask

    task automatic test_abort();
        pixel_y = 10'd480; pixel_x = 10'd0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b1 || car_x !== 10'd444) begin errors++; $display("FAIL abort_pre: got busy=%0b car_x=%0d expected busy=1 car_x=444", busy, car_x); end
        run_en = 1'b0;
        tick();
        checks++; if (car_x !== 10'd300) begin errors++; $display("FAIL abort_car_x: got %0d expected 300", car_x); end
        checks++; if (scroll_y !== 10'd0) begin errors++; $display("FAIL abort_scroll: got %0d expected 0", scroll_y); end
        checks++; if (speed !== 3'd0) begin errors++; $display("FAIL abort_speed: got %0d expected 0", speed); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", busy); end
        pixel_x = 10'd1; repeat (4) tick();
        pixel_y = 10'd0; pixel_x = 10'd5; repeat (4) tick();
        checks++; if (car_x !== 10'd300 || scroll_y !== 10'd0) begin errors++; $display("FAIL idle_stays: got car_x=%0d scroll=%0d expected 300/0", car_x, scroll_y); end
        run_en = 1'b1;
        tick();
        strobe(1'b0, 1'b0, 1'b1);
        exp_x = 300; exp_scroll = 0; exp_spd = 1; exp_cnt = 0; exp_dir = 0;
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL restart_speed: got %0d expected 1", speed); end
    endtask

    task automatic test_long_run();
`ifdef RACE_SPEED_RAMP_EN
        localparam int FRAMES = 80;
`else
        localparam int FRAMES = 485;
`endif
        wrap_seen = 1'b0;
        for (int f = 0; f < FRAMES; f++) begin
            do_frame(); model_frame();
`ifdef RACE_SPEED_RAMP_EN
            if (f == 0) begin
                checks++; if (speed !== 3'd1) begin errors++; $display("FAIL ramp_f1: got %0d expected 1", speed); end
            end
            if (f == 1) begin
                checks++; if (speed !== 3'd2) begin errors++; $display("FAIL ramp_f2: got %0d expected 2", speed); end
            end
`endif
            checks++;
            if (scroll_y !== 10'(exp_scroll) || speed !== 3'(exp_spd) || car_x !== 10'(exp_x)) begin
                errors++;
                $display("FAIL long_frame%0d: got scroll=%0d speed=%0d car_x=%0d expected %0d/%0d/%0d",
                         f, scroll_y, speed, car_x, exp_scroll, exp_spd, exp_x);
            end
        end
`ifdef RACE_SPEED_RAMP_EN
        checks++; if (speed !== 3'd7) begin errors++; $display("FAIL ramp_sat: got %0d expected 7", speed); end
`else
        checks++; if (speed !== 3'd1) begin errors++; $display("FAIL no_ramp_speed: got %0d expected 1", speed); end
        checks++; if (scroll_y !== 10'd5) begin errors++; $display("FAIL scroll_wrap: got %0d expected 5", scroll_y); end
`endif
        checks++; if (!wrap_seen) begin errors++; $display("FAIL wrap_reached: got 0 expected 1"); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_left_saturate();
        test_both_keys();
        test_hold();
        test_abort();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
